// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and data helpers for the data memory arbiter
// Purpose: access-size and FSM state encodings, plus the load extension and
//          store lane-merge functions used by dmem_arbiter.
// Ports:   none (package).
package dmem_pkg;

  localparam int unsigned XLEN = 32;

  // Size code 2'b11 has no enumerator; every consumer treats it as a word.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Loaded data always sits in the low lanes because the memory returns the
  // word that starts at the requested byte address.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      size,
                                                  input logic            is_unsigned);
    logic            fill;
    logic [XLEN-1:0] res;
    fill = 1'b0;
    res  = word;
    case (size)
      SZ_BYTE: begin
        fill = word[7] & ~is_unsigned;
        res  = {{(XLEN-8){fill}}, word[7:0]};
      end
      SZ_HALF: begin
        fill = word[15] & ~is_unsigned;
        res  = {{(XLEN-16){fill}}, word[15:0]};
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Store data replaces only the low lanes; the upper lanes are written back
  // unchanged so the full-word write leaves neighbouring bytes intact.
  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] wdata,
                                                  input logic [1:0]      size);
    logic [XLEN-1:0] res;
    case (size)
      SZ_BYTE: res = {old[XLEN-1:8], wdata[7:0]};
      SZ_HALF: res = {old[XLEN-1:16], wdata[15:0]};
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// rtl/dmem_rr_arb.sv - two-way round-robin arbiter
// Purpose: grants one of two requesters per cycle; on a tie the port that
//          was not granted last wins.
// Ports:   clk_i, rst_ni   clock, async active-low reset
//          req_i[1:0]      requests (bit 0 = m0, bit 1 = m1)
//          en_i            grants allowed this cycle (also gates pointer update)
//          gnt_o[1:0]      one-hot grant, combinational from req_i
module dmem_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // Index of the port that wins a tie.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
    end
    ptr_d = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory front end with RMW sub-word stores
// Purpose: shares a word-write, byte-addressed data memory between the core
//          (m0) and the debug/loader port (m1); sequences loads, word stores
//          and read-modify-write byte/half stores; extends sub-word loads.
// Ports:   clk_i, rst_ni                 clock, async active-low reset
//          mX_req/we/size/unsigned/addr/wdata_i   request from master X
//          mX_gnt_o                      request accepted this cycle
//          mX_rvalid_o, mX_rdata_o       one-cycle completion, load data
//          mem_we_o, mem_addr_o, mem_wdata_o   memory command
//          mem_rdata_i                   combinational read word at mem_addr_o
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [1:0]            m0_size_i,
  input  logic                  m0_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [ADDR_WIDTH-1:0] m0_wdata_i,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [1:0]            m1_size_i,
  input  logic                  m1_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [ADDR_WIDTH-1:0] m1_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m1_gnt_o,
  output logic                  m0_rvalid_o,
  output logic                  m1_rvalid_o,
  output logic [ADDR_WIDTH-1:0] m0_rdata_o,
  output logic [ADDR_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [ADDR_WIDTH-1:0] mem_wdata_o,
  input  logic [ADDR_WIDTH-1:0] mem_rdata_i
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wdata_q, wdata_d;  // store data, then merged write word
  logic [ADDR_WIDTH-1:0] resp_q, resp_d;

  logic [1:0] gnt;
  logic       arb_en;
  logic       sel_we, sel_uns;
  logic [1:0] sel_size;
  logic [ADDR_WIDTH-1:0] sel_addr, sel_wdata;

  // Gating with rst_ni keeps the grants low while reset is held.
  assign arb_en = (state_q == ST_IDLE) && rst_ni;

  dmem_rr_arb u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  ({m1_req_i, m0_req_i}),
    .en_i   (arb_en),
    .gnt_o  (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  assign sel_we    = gnt[1] ? m1_we_i       : m0_we_i;
  assign sel_size  = gnt[1] ? m1_size_i     : m0_size_i;
  assign sel_uns   = gnt[1] ? m1_unsigned_i : m0_unsigned_i;
  assign sel_addr  = gnt[1] ? m1_addr_i     : m0_addr_i;
  assign sel_wdata = gnt[1] ? m1_wdata_i    : m0_wdata_i;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          we_d    = sel_we;
          size_d  = sel_size;
          uns_d   = sel_uns;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          resp_d  = '0;
          // Sub-word stores read the old word first.
          if (!sel_we || sel_size == SZ_BYTE || sel_size == SZ_HALF) state_d = ST_READ;
          else                                                      state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        mem_addr_o = addr_q;
        if (we_q) begin
          wdata_d = store_merge(mem_rdata_i, wdata_q, size_q);
          state_d = ST_WRITE;
        end else begin
          resp_d  = load_extend(mem_rdata_i, size_q, uns_q);
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        state_d     = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  end

  // resp_q is cleared on grant, so stores complete with zero rdata.
  assign m0_rvalid_o = (state_q == ST_RESP) && !owner_q;
  assign m1_rvalid_o = (state_q == ST_RESP) &&  owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? resp_q : '0;
  assign m1_rdata_o  = m1_rvalid_o ? resp_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m0_we_i, m0_unsigned_i;
  logic [1:0]  m0_size_i;
  logic [31:0] m0_addr_i, m0_wdata_i;
  logic        m1_req_i, m1_we_i, m1_unsigned_i;
  logic [1:0]  m1_size_i;
  logic [31:0] m1_addr_i, m1_wdata_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  dmem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_size_i(m0_size_i),
    .m0_unsigned_i(m0_unsigned_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_size_i(m1_size_i),
    .m1_unsigned_i(m1_unsigned_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Byte-addressed memory, 4 KiB window (address bits [11:0]).
  logic [7:0]  mem [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        mem_ready = 1'b0;
  logic [11:0] ma;
  assign ma = mem_addr_o[11:0];
  assign mem_rdata_i = {mem[ma+12'd3], mem[ma+12'd2], mem[ma+12'd1], mem[ma]};

  always @(negedge clk_i) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[0] <= 8'hEF; mem[1] <= 8'hBE; mem[2] <= 8'hAD; mem[3] <= 8'hDE;
      mem_ready <= 1'b1;
    end else if (mem_we_o) begin
      mem[ma]        <= mem_wdata_o[7:0];
      mem[ma+12'd1]  <= mem_wdata_o[15:8];
      mem[ma+12'd2]  <= mem_wdata_o[23:16];
      mem[ma+12'd3]  <= mem_wdata_o[31:24];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_req_i = req; m0_we_i = we; m0_size_i = sz; m0_unsigned_i = uns;
      m0_addr_i = addr; m0_wdata_i = wdata;
    end else begin
      m1_req_i = req; m1_we_i = we; m1_size_i = sz; m1_unsigned_i = uns;
      m1_addr_i = addr; m1_wdata_i = wdata;
    end
  endtask

  // One access on port p, starting in an IDLE cycle. Reports cycles waited
  // for grant, grant-to-rvalid latency, write-enable cycles and write word.
  task automatic run_txn(input int p, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int wait_g, output int lat,
                         output int we_cyc, output int we_cnt, output logic [31:0] wword,
                         output logic stray);
    logic g;
    rdata = '0; wait_g = -1; lat = -1; we_cyc = 0; we_cnt = 0; wword = '0; stray = 1'b0;
    @(posedge clk_i); #1;
    drive(p, 1'b1, we, sz, uns, addr, wdata);
    for (int w = 0; w < 8; w++) begin
      #1;
      g = (p == 0) ? m0_gnt_o : m1_gnt_o;
      if (g) begin
        wait_g = w;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (wait_g < 0) begin
      drive(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      return;
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk_i); #1;
      // Inputs are free to change once granted.
      if (c == 1) drive(p, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
      #1;
      if (mem_we_o) begin
        we_cnt++;
        we_cyc = c;
        wword  = mem_wdata_o;
      end
      if ((p == 0) ? m1_rvalid_o : m0_rvalid_o) stray = 1'b1;
      if ((p == 0) ? m0_rvalid_o : m1_rvalid_o) begin
        lat   = c;
        rdata = (p == 0) ? m0_rdata_o : m1_rdata_o;
        break;
      end
    end
    drive(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  typedef struct {
    int          p;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wword;
    int          exp_lat;
    int          exp_wec;
  } vec_t;

  vec_t vt [15];

  initial begin : timeout
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rd, ww, w, exp;
    int wg, lat, wec, wcnt, n, diffs;
    logic stray, g0, g1, we;
    logic [1:0] sz;
    logic uns;
    logic [31:0] addr, wdata;
    int p;

    vt[0]  = '{0, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0,        32'hDEADBEEF, 32'h0,        2, 0};
    vt[1]  = '{0, 1'b0, 2'b00, 1'b0, 32'h10000, 32'h0,        32'hFFFFFFEF, 32'h0,        2, 0};
    vt[2]  = '{0, 1'b0, 2'b00, 1'b1, 32'h10000, 32'h0,        32'h000000EF, 32'h0,        2, 0};
    vt[3]  = '{1, 1'b0, 2'b01, 1'b0, 32'h10002, 32'h0,        32'hFFFFDEAD, 32'h0,        2, 0};
    vt[4]  = '{1, 1'b0, 2'b01, 1'b1, 32'h10002, 32'h0,        32'h0000DEAD, 32'h0,        2, 0};
    vt[5]  = '{1, 1'b1, 2'b00, 1'b0, 32'h10001, 32'hFFFFFF55, 32'h0,        32'h00DEAD55, 3, 2};
    vt[6]  = '{0, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0,        32'hDEAD55EF, 32'h0,        2, 0};
    vt[7]  = '{0, 1'b1, 2'b10, 1'b0, 32'h10010, 32'h12345678, 32'h0,        32'h12345678, 2, 1};
    vt[8]  = '{1, 1'b0, 2'b10, 1'b0, 32'h10010, 32'h0,        32'h12345678, 32'h0,        2, 0};
    vt[9]  = '{0, 1'b1, 2'b01, 1'b0, 32'h10012, 32'hABCDCAFE, 32'h0,        32'h0000CAFE, 3, 2};
    vt[10] = '{0, 1'b0, 2'b10, 1'b0, 32'h10010, 32'h0,        32'hCAFE5678, 32'h0,        2, 0};
    vt[11] = '{1, 1'b0, 2'b00, 1'b0, 32'h10013, 32'h0,        32'hFFFFFFCA, 32'h0,        2, 0};
    vt[12] = '{1, 1'b0, 2'b11, 1'b0, 32'h10010, 32'h0,        32'hCAFE5678, 32'h0,        2, 0};
    vt[13] = '{0, 1'b0, 2'b10, 1'b0, 32'h10001, 32'h0,        32'h00DEAD55, 32'h0,        2, 0};
    vt[14] = '{1, 1'b0, 2'b01, 1'b1, 32'h10011, 32'h0,        32'h0000FE56, 32'h0,        2, 0};

    // Reset state with both ports requesting.
    rst_ni = 1'b0;
    drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10000, 32'h1);
    drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10004, 32'h2);
    #2;
    check("reset m0_gnt", {31'h0, m0_gnt_o}, 32'h0);
    check("reset m1_gnt", {31'h0, m1_gnt_o}, 32'h0);
    check("reset rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
    check("reset mem_we", {31'h0, mem_we_o}, 32'h0);
    check("reset mem_addr", mem_addr_o, 32'h0);
    check("reset mem_wdata", mem_wdata_o, 32'h0);
    check("reset rdata", m0_rdata_o | m1_rdata_o, 32'h0);
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 15; i++) begin
      run_txn(vt[i].p, vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wdata,
              rd, wg, lat, wec, wcnt, ww, stray);
      check($sformatf("vec%0d grant_wait", i), wg, 0);
      check($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
      check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d we_count", i), wcnt, vt[i].we ? 1 : 0);
      check($sformatf("vec%0d other_rvalid", i), {31'h0, stray}, 32'h0);
      if (vt[i].we) begin
        check($sformatf("vec%0d we_cycle", i), wec, vt[i].exp_wec);
        check($sformatf("vec%0d write_word", i), ww, vt[i].exp_wword);
      end
    end

    // Both ports request loads continuously from reset: alternate, 3 apart.
    do_reset();
    @(posedge clk_i); #1;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10010, 32'h0);
    for (int c = 0; c < 12; c++) begin
      #1;
      g0 = m0_gnt_o;
      g1 = m1_gnt_o;
      check($sformatf("rr c%0d both_gnt", c), {31'h0, g0 & g1}, 32'h0);
      check($sformatf("rr c%0d m0_gnt", c), {31'h0, g0}, {31'h0, (c % 6) == 0});
      check($sformatf("rr c%0d m1_gnt", c), {31'h0, g1}, {31'h0, (c % 6) == 3});
      @(posedge clk_i); #1;
    end
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk_i);

    // Reset during WRITE, before the falling edge.
    @(posedge clk_i); #1;
    drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10020, 32'hA5A5A5A5);
    #1;
    check("abort grant", {31'h0, m0_gnt_o}, 32'h1);
    @(posedge clk_i); #1;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("abort in_write we", {31'h0, mem_we_o}, 32'h1);
    #1 rst_ni = 1'b0;
    #1;
    check("abort we_dropped", {31'h0, mem_we_o}, 32'h0);
    stray = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i); #1;
      if (m0_rvalid_o || m1_rvalid_o) stray = 1'b1;
    end
    check("abort no_rvalid", {31'h0, stray}, 32'h0);
    check("abort mem_unchanged", {mem[12'h023], mem[12'h022], mem[12'h021], mem[12'h020]}, 32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h10020, 32'h0, rd, wg, lat, wec, wcnt, ww, stray);
    check("after_abort grant_wait", wg, 0);
    check("after_abort latency", lat, 2);
    check("after_abort rdata", rd, 32'h0);

    // Randomized accesses against a byte-array reference model.
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
    for (int t = 0; t < 150; t++) begin
      p     = int'($urandom_range(0, 1));
      we    = 1'($urandom);
      sz    = 2'($urandom);
      uns   = 1'($urandom);
      addr  = 32'h10000 + $urandom_range(0, 255);
      wdata = $urandom;
      run_txn(p, we, sz, uns, addr, wdata, rd, wg, lat, wec, wcnt, ww, stray);
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      if (we) begin
        for (int b = 0; b < n; b++) ref_mem[addr[11:0] + 12'(b)] = wdata[8*b +: 8];
        exp = 32'h0;
      end else begin
        w = {ref_mem[addr[11:0] + 12'd3], ref_mem[addr[11:0] + 12'd2],
             ref_mem[addr[11:0] + 12'd1], ref_mem[addr[11:0]]};
        if (n == 1)      exp = uns ? {24'h0, w[7:0]}  : 32'($signed(w[7:0]));
        else if (n == 2) exp = uns ? {16'h0, w[15:0]} : 32'($signed(w[15:0]));
        else             exp = w;
      end
      check($sformatf("rand%0d grant_wait", t), wg, 0);
      check($sformatf("rand%0d latency", t), lat, (we && n < 4) ? 3 : 2);
      check($sformatf("rand%0d rdata", t), rd, exp);
      check($sformatf("rand%0d other_rvalid", t), {31'h0, stray}, 32'h0);
    end
    @(posedge clk_i);
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("final memory image diffs", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
